// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry and
// the write-scheduler state encoding.
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_REG_DEPTH  = 1 << RF_ADDR_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at ptr and wraps,
// first pending request wins; gnt is one-hot or zero.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write scheduler: zero-fill sweep after reset
// or clear, then round-robin arbitration of write requesters.
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_REQ    = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_req,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write_en,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          init_done
);

    localparam int REG_DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] K_LAST =
        ADDR_WIDTH'(REG_DEPTH - 1);
    localparam logic [PTR_W-1:0] P_LAST = PTR_W'(NUM_REQ - 1);

    rf_state_e             state;
    logic [ADDR_WIDTH-1:0] k;
    logic [PTR_W-1:0]      ptr;

    logic [NUM_REQ-1:0]    gnt;
    logic                  run_ok;
    logic                  xfer;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    // A clear in RUN masks every grant so the pending request survives.
    assign run_ok    = (state == RUN) && !clear_req;
    assign req_ready = run_ok ? gnt : '0;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_nxt = (gnt_idx == P_LAST) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            k          <= '0;
            ptr        <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            init_done  <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    write_en   <= 1'b1;
                    write_addr <= k;
                    write_data <= '0;
                    if (k == K_LAST) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        k         <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state     <= INIT;
                        k         <= '0;
                        init_done <= 1'b0;
                        write_en  <= 1'b0;
                    end else if (xfer) begin
                        write_en   <= 1'b1;
                        write_addr <= sel_addr;
                        write_data <= sel_data;
                        ptr        <= ptr_nxt;
                    end else begin
                        write_en <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
